// File: rtl/traffic_phase_sequencer.sv
// Two-way intersection phase sequencer: six fixed phases timed by an 8-bit
// saturating elapsed-tick counter, with NS green held until EW requests.
`timescale 1ns/1ps
module traffic_phase_sequencer #(
  parameter int unsigned GREEN_T  = 30,
  parameter int unsigned YELLOW_T = 4,
  parameter int unsigned ALLRED_T = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       tick,
  input  logic       ew_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [2:0] phase,
  output logic [7:0] elapsed,
  output logic       phase_done
);

  typedef enum logic [2:0] {
    ALLRED_A  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_B  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5
  } state_t;

  localparam logic [7:0] GREEN_D  = 8'(GREEN_T);
  localparam logic [7:0] YELLOW_D = 8'(YELLOW_T);
  localparam logic [7:0] ALLRED_D = 8'(ALLRED_T);

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // Kept as plain logic so an out-of-range code can exist and be recovered from.
  logic [2:0] phase_r;
  logic [7:0] elapsed_r;
  logic       phase_done_r;

  state_t     state_s;
  state_t     succ_s;
  logic [7:0] elapsed_s;
  logic       done_s;
  logic       adv_s;
  logic       legal_s;
  logic       hit_s;
  logic [7:0] dur_s;
  logic [8:0] sum_s;
  logic [2:0] ns_s;
  logic [2:0] ew_s;

  assign adv_s   = en & tick;
  assign legal_s = (phase_r <= 3'd5);
  assign sum_s   = {1'b0, elapsed_r} + 9'd1;
  assign hit_s   = (sum_s >= {1'b0, dur_s});

  // Duration and successor of the current phase.
  always_comb begin
    dur_s  = ALLRED_D;
    succ_s = ALLRED_A;
    case (phase_r)
      ALLRED_A:  begin dur_s = ALLRED_D; succ_s = NS_GREEN;  end
      NS_GREEN:  begin dur_s = GREEN_D;  succ_s = NS_YELLOW; end
      NS_YELLOW: begin dur_s = YELLOW_D; succ_s = ALLRED_B;  end
      ALLRED_B:  begin dur_s = ALLRED_D; succ_s = EW_GREEN;  end
      EW_GREEN:  begin dur_s = GREEN_D;  succ_s = EW_YELLOW; end
      EW_YELLOW: begin dur_s = YELLOW_D; succ_s = ALLRED_A;  end
      default:   begin dur_s = ALLRED_D; succ_s = ALLRED_A;  end
    endcase
  end

  // Next phase, elapsed count and phase-change pulse.
  always_comb begin
    state_s   = state_t'(phase_r);
    elapsed_s = elapsed_r;
    done_s    = 1'b0;
    if (!legal_s) begin
      state_s   = ALLRED_A;
      elapsed_s = 8'd0;
    end else if (adv_s) begin
      // NS green only yields when EW is asking at the tick itself.
      if (hit_s && ((phase_r != NS_GREEN) || ew_req)) begin
        state_s   = succ_s;
        elapsed_s = 8'd0;
        done_s    = 1'b1;
      end else begin
        elapsed_s = sum_s[8] ? 8'hFF : sum_s[7:0];
      end
    end else begin
      elapsed_s = elapsed_r;
    end
  end

  // Phase, elapsed and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r      <= ALLRED_A;
      elapsed_r    <= 8'd0;
      phase_done_r <= 1'b0;
    end else begin
      phase_r      <= state_s;
      elapsed_r    <= elapsed_s;
      phase_done_r <= done_s;
    end
  end

  // Lamp decode straight from the phase register; illegal codes show all red.
  always_comb begin
    ns_s = LAMP_R;
    ew_s = LAMP_R;
    case (phase_r)
      ALLRED_A:  begin ns_s = LAMP_R; ew_s = LAMP_R; end
      NS_GREEN:  begin ns_s = LAMP_G; ew_s = LAMP_R; end
      NS_YELLOW: begin ns_s = LAMP_Y; ew_s = LAMP_R; end
      ALLRED_B:  begin ns_s = LAMP_R; ew_s = LAMP_R; end
      EW_GREEN:  begin ns_s = LAMP_R; ew_s = LAMP_G; end
      EW_YELLOW: begin ns_s = LAMP_R; ew_s = LAMP_Y; end
      default:   begin ns_s = LAMP_R; ew_s = LAMP_R; end
    endcase
  end

  assign ns_light   = ns_s;
  assign ew_light   = ew_s;
  assign phase      = phase_r;
  assign elapsed    = elapsed_r;
  assign phase_done = phase_done_r;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer: table-driven phase walk, request hold,
// reset abort, enable freeze, continuous tick and illegal-code recovery.
`timescale 1ns/1ps
module tb_traffic_phase_sequencer;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       tick;
  logic       ew_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [2:0] phase;
  logic [7:0] elapsed;
  logic       phase_done;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic [2:0] ph;
    logic [7:0] el;
    logic       dn;
  } exp_t;

  typedef struct {
    logic       en;
    logic       ew;
    logic [2:0] ph;
    logic [7:0] el;
    logic       dn;
  } vec_t;

  exp_t sbq[$];
  vec_t walk[13];
  vec_t burst[12];

  traffic_phase_sequencer #(
    .GREEN_T (3),
    .YELLOW_T(2),
    .ALLRED_T(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .tick      (tick),
    .ew_req    (ew_req),
    .ns_light  (ns_light),
    .ew_light  (ew_light),
    .phase     (phase),
    .elapsed   (elapsed),
    .phase_done(phase_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] lamps(input logic [2:0] ph);
    case (ph)
      3'd1:    return {3'b001, 3'b100};
      3'd2:    return {3'b010, 3'b100};
      3'd4:    return {3'b100, 3'b001};
      3'd5:    return {3'b100, 3'b010};
      default: return {3'b100, 3'b100};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic check_out(input exp_t x);
    logic [5:0] l;
    l = lamps(x.ph);
    chk("phase", 32'(phase), 32'(x.ph));
    chk("elapsed", 32'(elapsed), 32'(x.el));
    chk("phase_done", 32'(phase_done), 32'(x.dn));
    chk("ns_light", 32'(ns_light), 32'(l[5:3]));
    chk("ew_light", 32'(ew_light), 32'(l[2:0]));
  endtask

  // Drive one cycle at the falling edge, queue the expectation, check after the rising edge.
  task automatic step(input logic e, input logic t, input logic ew,
                      input logic [2:0] ph, input logic [7:0] el, input logic dn);
    exp_t x;
    exp_t y;
    en = e; tick = t; ew_req = ew;
    x.ph = ph; x.el = el; x.dn = dn;
    sbq.push_back(x);
    @(posedge clk);
    @(negedge clk);
    y = sbq.pop_front();
    check_out(y);
  endtask

  task automatic tick_step(input logic e, input logic ew_t, input logic ew_i,
                           input logic [2:0] ph, input logic [7:0] el, input logic dn);
    step(e, 1'b1, ew_t, ph, el, dn);
    repeat (3) step(e, 1'b0, ew_i, ph, el, 1'b0);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; en = 1'b0; tick = 1'b0; ew_req = 1'b0;

    walk[0]  = '{1'b1, 1'b1, 3'd1, 8'd0, 1'b1};
    walk[1]  = '{1'b1, 1'b1, 3'd1, 8'd1, 1'b0};
    walk[2]  = '{1'b1, 1'b1, 3'd1, 8'd2, 1'b0};
    walk[3]  = '{1'b1, 1'b1, 3'd2, 8'd0, 1'b1};
    walk[4]  = '{1'b1, 1'b1, 3'd2, 8'd1, 1'b0};
    walk[5]  = '{1'b1, 1'b1, 3'd3, 8'd0, 1'b1};
    walk[6]  = '{1'b1, 1'b1, 3'd4, 8'd0, 1'b1};
    walk[7]  = '{1'b1, 1'b1, 3'd4, 8'd1, 1'b0};
    walk[8]  = '{1'b0, 1'b1, 3'd4, 8'd1, 1'b0};
    walk[9]  = '{1'b1, 1'b1, 3'd4, 8'd2, 1'b0};
    walk[10] = '{1'b1, 1'b1, 3'd5, 8'd0, 1'b1};
    walk[11] = '{1'b1, 1'b1, 3'd5, 8'd1, 1'b0};
    walk[12] = '{1'b1, 1'b1, 3'd0, 8'd0, 1'b1};

    burst[0]  = '{1'b1, 1'b1, 3'd4, 8'd0, 1'b1};
    burst[1]  = '{1'b1, 1'b1, 3'd4, 8'd1, 1'b0};
    burst[2]  = '{1'b1, 1'b1, 3'd4, 8'd2, 1'b0};
    burst[3]  = '{1'b1, 1'b1, 3'd5, 8'd0, 1'b1};
    burst[4]  = '{1'b1, 1'b1, 3'd5, 8'd1, 1'b0};
    burst[5]  = '{1'b1, 1'b1, 3'd0, 8'd0, 1'b1};
    burst[6]  = '{1'b1, 1'b1, 3'd1, 8'd0, 1'b1};
    burst[7]  = '{1'b1, 1'b1, 3'd1, 8'd1, 1'b0};
    burst[8]  = '{1'b1, 1'b1, 3'd1, 8'd2, 1'b0};
    burst[9]  = '{1'b1, 1'b1, 3'd2, 8'd0, 1'b1};
    burst[10] = '{1'b1, 1'b1, 3'd2, 8'd1, 1'b0};
    burst[11] = '{1'b1, 1'b1, 3'd3, 8'd0, 1'b1};

    repeat (2) @(negedge clk);
    check_out('{3'd0, 8'd0, 1'b0});
    rst_n = 1'b1;

    // No advance until a tick arrives after reset release.
    step(1'b1, 1'b0, 1'b1, 3'd0, 8'd0, 1'b0);

    // Full cycle with EW always requesting, tick every fourth clock.
    for (int i = 0; i < 13; i++)
      tick_step(walk[i].en, walk[i].ew, walk[i].ew, walk[i].ph, walk[i].el, walk[i].dn);

    // NS green held without request; elapsed saturates at 255.
    tick_step(1'b1, 1'b0, 1'b0, 3'd1, 8'd0, 1'b1);
    for (int k = 1; k <= 260; k++)
      tick_step(1'b1, 1'b0, 1'b0, 3'd1, (k > 255) ? 8'd255 : 8'(k), 1'b0);
    // Request raised only between ticks is not seen.
    tick_step(1'b1, 1'b0, 1'b1, 3'd1, 8'd255, 1'b0);
    tick_step(1'b1, 1'b0, 1'b0, 3'd1, 8'd255, 1'b0);
    tick_step(1'b1, 1'b1, 1'b1, 3'd2, 8'd0, 1'b1);

    // Walk to EW_GREEN elapsed 2, then abort with an asynchronous reset.
    tick_step(1'b1, 1'b1, 1'b1, 3'd2, 8'd1, 1'b0);
    tick_step(1'b1, 1'b1, 1'b1, 3'd3, 8'd0, 1'b1);
    tick_step(1'b1, 1'b1, 1'b1, 3'd4, 8'd0, 1'b1);
    tick_step(1'b1, 1'b1, 1'b1, 3'd4, 8'd1, 1'b0);
    tick_step(1'b1, 1'b1, 1'b1, 3'd4, 8'd2, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_out('{3'd0, 8'd0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1, 3'd0, 8'd0, 1'b0);
    tick_step(1'b1, 1'b1, 1'b1, 3'd1, 8'd0, 1'b1);

    // Freeze in NS_YELLOW with elapsed 1 for 20 ticks, then resume.
    tick_step(1'b1, 1'b1, 1'b1, 3'd1, 8'd1, 1'b0);
    tick_step(1'b1, 1'b1, 1'b1, 3'd1, 8'd2, 1'b0);
    tick_step(1'b1, 1'b1, 1'b1, 3'd2, 8'd0, 1'b1);
    tick_step(1'b1, 1'b1, 1'b1, 3'd2, 8'd1, 1'b0);
    for (int k = 0; k < 20; k++)
      tick_step(1'b0, 1'b1, 1'b1, 3'd2, 8'd1, 1'b0);
    tick_step(1'b1, 1'b1, 1'b1, 3'd3, 8'd0, 1'b1);

    // Tick held high: one advance per clock.
    for (int i = 0; i < 12; i++)
      step(burst[i].en, 1'b1, burst[i].ew, burst[i].ph, burst[i].el, burst[i].dn);

    // Illegal code recovery from EW_GREEN with nonzero elapsed.
    step(1'b1, 1'b1, 1'b1, 3'd4, 8'd0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 3'd4, 8'd1, 1'b0);
    en = 1'b0; tick = 1'b0;
    force dut.phase_r = 3'd6;
    #1;
    chk("illegal_phase", 32'(phase), 32'd6);
    chk("illegal_ns_light", 32'(ns_light), 32'(3'b100));
    chk("illegal_ew_light", 32'(ew_light), 32'(3'b100));
    release dut.phase_r;
    step(1'b0, 1'b0, 1'b1, 3'd0, 8'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
